// File: rtl/ysyx_22050854_axi_pkg.sv
// Shared AXI read-side encodings, master IDs and responder FSM states.
// The arbiter uses the same ID constants.
package ysyx_22050854_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  localparam logic [3:0] ID_FLASH  = 4'd0;
  localparam logic [3:0] ID_DCACHE = 4'd1;
  localparam logic [3:0] ID_DEVICE = 4'd2;
  localparam logic [3:0] ID_ICACHE = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_e;

  // Only FIXED/INCR with beats up to 8 bytes are served.
  function automatic logic req_err(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return burst[1] || (size > 3'd3);
  endfunction

endpackage

// File: rtl/ysyx_22050854_ar_fifo.sv
// Small synchronous FIFO holding accepted AR requests.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module ysyx_22050854_ar_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ysyx_22050854_axi_read_responder.sv
// AXI4 read responder: queues AR requests and serves them beat by beat
// from a 1-cycle-latency memory port, in strict arrival order.
module ysyx_22050854_axi_read_responder
  import ysyx_22050854_axi_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int AR_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AR_W = ID_W + ADDR_W + 13;

  rd_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [AR_W-1:0]   fifo_din;
  logic [AR_W-1:0]   fifo_dout;

  logic [ID_W-1:0]   f_id;
  logic [ADDR_W-1:0] f_addr;
  logic [7:0]        f_len;
  logic [2:0]        f_size;
  logic [1:0]        f_burst;

  logic              err_q;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] nxt_addr;

  assign s_arready = !fifo_full && !reset;
  assign fifo_din  = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign {f_id, f_addr, f_len, f_size, f_burst} = fifo_dout;

  assign err_q    = req_err(burst_q, size_q);
  assign step     = ADDR_W'(1) << size_q;
  assign nxt_addr = (burst_q == BURST_INCR) ? addr_q + step : addr_q;

  ysyx_22050854_ar_fifo #(
    .W     (AR_W),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s_arvalid && s_arready),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      s_rvalid  <= 1'b0;
      s_rid     <= '0;
      s_rdata   <= '0;
      s_rresp   <= '0;
      s_rlast   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            addr_q    <= f_addr;
            id_q      <= f_id;
            len_q     <= f_len;
            size_q    <= f_size;
            burst_q   <= f_burst;
            beat_cnt  <= '0;
            mem_ren   <= !req_err(f_burst, f_size);
            mem_raddr <= {f_addr[ADDR_W-1:3], 3'b000};
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_ren <= 1'b0;
          // Error bursts never touch memory: answer straight away.
          if (err_q) begin
            s_rvalid <= 1'b1;
            s_rid    <= id_q;
            s_rdata  <= '0;
            s_rresp  <= RESP_SLVERR;
            s_rlast  <= (beat_cnt == len_q);
            state    <= ST_RESP;
          end else begin
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          s_rvalid <= 1'b1;
          s_rid    <= id_q;
          s_rdata  <= mem_rdata;
          s_rresp  <= RESP_OKAY;
          s_rlast  <= (beat_cnt == len_q);
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            if (s_rlast) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt  <= beat_cnt + 8'd1;
              addr_q    <= nxt_addr;
              mem_ren   <= !err_q;
              mem_raddr <= {nxt_addr[ADDR_W-1:3], 3'b000};
              state     <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_axi_read_responder.sv
// Scoreboard bench for the AXI read responder.
// Expected beats and memory addresses are queued when an AR is accepted.
module tb_ysyx_22050854_axi_read_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [3:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata = '0;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       rq[$];
  logic [31:0] aq[$];
  beat_t       e;
  int          checks = 0;
  int          failures = 0;
  int          ren_cnt = 0;

  ysyx_22050854_axi_read_responder dut (
    .clock     (clock),
    .reset     (reset),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_ren) mem_rdata <= {mem_raddr, ~mem_raddr};
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_ren) begin
        ren_cnt++;
        if (aq.size() == 0) chk("mem_ren_unexp", 64'(mem_ren), 64'd0);
        else chk("mem_raddr", 64'(mem_raddr), 64'(aq.pop_front()));
      end
      if (s_rvalid && s_rready) begin
        if (rq.size() == 0) begin
          chk("r_unexp", 64'(s_rvalid), 64'd0);
        end else begin
          e = rq.pop_front();
          chk("rid",   64'(s_rid),   64'(e.id));
          chk("rdata", s_rdata,      e.data);
          chk("rresp", 64'(s_rresp), 64'(e.resp));
          chk("rlast", 64'(s_rlast), 64'(e.last));
        end
      end
    end
  end

  task automatic expect_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
    logic        err;
    logic [31:0] a;
    logic [31:0] al;
    beat_t       b;
    err = burst[1] || (size > 3'd3);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      al = {a[31:3], 3'b000};
      b.id   = id;
      b.data = err ? 64'd0 : {al, ~al};
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      rq.push_back(b);
      if (!err) aq.push_back(al);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    s_arvalid = 1'b1;
    s_arid    = id;
    s_araddr  = addr;
    s_arlen   = len;
    s_arsize  = size;
    s_arburst = burst;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    logic ok;
    int   n;
    ok = 1'b0;
    n = 0;
    drive_ar(id, addr, len, size, burst);
    while (!ok && n < 20) begin
      @(negedge clock);
      ok = s_arready;
      @(posedge clock);
      n++;
    end
    if (ok) expect_burst(id, addr, len, size, burst);
    #1;
    s_arvalid = 1'b0;
    chk("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    chk(tag, 64'(rq.size() + aq.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] cap_data;
    logic [3:0]  cap_id;
    logic        cap_last;
    int          snap;
    int          n;

    #12;
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_rvalid",  64'(s_rvalid),  64'd0);
    chk("rst_mem_ren", 64'(mem_ren),   64'd0);
    chk("rst_rlast",   64'(s_rlast),   64'd0);
    chk("rst_rdata",   s_rdata,        64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_arready", 64'(s_arready), 64'd1);
    @(posedge clock);
    #1;

    // INCR burst and first-beat latency
    send_ar(4'd3, 32'h8000_0000, 8'd1, 3'd3, 2'b01);
    n = 0;
    while (!s_rvalid && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("t1_latency", 64'(n), 64'd3);
    wait_drain("t1_drain");

    // FIXED burst
    send_ar(4'd2, 32'ha000_03fc, 8'd2, 3'd2, 2'b00);
    wait_drain("t2_drain");

    // back-to-back ARs while a stalled burst keeps the FSM busy
    s_rready = 1'b0;
    send_ar(4'd0, 32'h0000_1000, 8'd3, 3'd3, 2'b01);
    @(posedge clock);
    #1;
    drive_ar(4'd3, 32'h0000_2000, 8'd1, 3'd3, 2'b01);
    @(negedge clock);
    chk("t3_ar0_ready", 64'(s_arready), 64'd1);
    @(posedge clock);
    expect_burst(4'd3, 32'h0000_2000, 8'd1, 3'd3, 2'b01);
    #1;
    drive_ar(4'd1, 32'h0000_3000, 8'd0, 3'd3, 2'b01);
    @(negedge clock);
    chk("t3_ar1_ready", 64'(s_arready), 64'd1);
    @(posedge clock);
    expect_burst(4'd1, 32'h0000_3000, 8'd0, 3'd3, 2'b01);
    #1;
    drive_ar(4'd2, 32'h0000_4000, 8'd0, 3'd3, 2'b01);
    @(negedge clock);
    chk("t3_ar2_ready", 64'(s_arready), 64'd0);
    @(posedge clock);
    #1;
    s_arvalid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    s_rready = 1'b1;
    wait_drain("t3_drain");

    // backpressure on beat 0
    s_rready = 1'b0;
    send_ar(4'd1, 32'h0000_5008, 8'd1, 3'd3, 2'b01);
    n = 0;
    while (!s_rvalid && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    cap_data = s_rdata;
    cap_id   = s_rid;
    cap_last = s_rlast;
    snap     = ren_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_rvalid", 64'(s_rvalid), 64'd1);
      chk("t4_rdata",  s_rdata,       cap_data);
      chk("t4_rid",    64'(s_rid),    64'(cap_id));
      chk("t4_rlast",  64'(s_rlast),  64'(cap_last));
    end
    chk("t4_no_ren", 64'(ren_cnt - snap), 64'd0);
    @(posedge clock);
    #1;
    s_rready = 1'b1;
    wait_drain("t4_drain");

    // unsupported burst type and oversized beat
    snap = ren_cnt;
    send_ar(4'd1, 32'h0000_6000, 8'd3, 3'd3, 2'b10);
    wait_drain("t5_drain");
    send_ar(4'd2, 32'h0000_7000, 8'd0, 3'd4, 2'b01);
    wait_drain("t5b_drain");
    chk("t5_no_ren", 64'(ren_cnt - snap), 64'd0);

    // reset between edges while beat 1 is on the bus
    send_ar(4'd3, 32'h0000_8000, 8'd1, 3'd3, 2'b01);
    n = 0;
    while (!(s_rvalid && rq.size() == 1) && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("t6_reach", 64'(n < 30), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rvalid",  64'(s_rvalid),  64'd0);
    chk("t6_rlast",   64'(s_rlast),   64'd0);
    chk("t6_arready", 64'(s_arready), 64'd0);
    chk("t6_mem_ren", 64'(mem_ren),   64'd0);
    rq.delete();
    aq.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rel_arready", 64'(s_arready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t6_no_stale", 64'(s_rvalid), 64'd0);
    end
    @(posedge clock);
    #1;
    send_ar(4'd0, 32'h0000_9010, 8'd0, 3'd3, 2'b01);
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
